fadd_share_arb_81: RTL

- Shares one pipelined float adder (float_add_81) among NREQ requesters.
- Each requester issues single-precision add or subtract requests over a valid/ready handshake.
- The block round-robin arbitrates, issues at most one operation per cycle into the adder, tracks each in-flight operation with a tag pipeline matched to the adder latency, and routes each result back to its originator as a one-cycle response pulse.
- The adder has no valid or stall signals; this block supplies all sequencing.

---
 rtl/fadd_share_arb_81_pkg.sv | 31 +++
 rtl/fadd_share_arb_81_if.sv | 44 ++++
 rtl/fadd_share_arb_81_rr.sv | 55 +++++
 rtl/fadd_share_arb_81.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fadd_share_arb_81_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fadd_pkg_81 (package)
// Description : Shared constants and types for the float-adder share block.
//               FP_W / FP_SIGN_BIT describe the IEEE-754 single format,
//               ADD_LAT_DEFAULT is the adder pipeline depth, and tag_t is
//               one entry of the in-flight tag shift register.
// Revision    : 1.0 - initial release
// ============================================================================
package fadd_pkg_81;

  localparam int FP_W            = 32;
  localparam int FP_SIGN_BIT     = 31;
  localparam int ADD_LAT_DEFAULT = 6;
  // Wide enough for the largest supported requester count (8).
  localparam int TAG_ID_W        = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // A-B is issued to the adder as A+(-B): only the sign bit of B changes,
  // so zeros and denormals otherwise pass through untouched.
  function automatic logic [FP_W-1:0] negate_if(input logic [FP_W-1:0] x,
                                                 input logic            sub);
    return sub ? {~x[FP_SIGN_BIT], x[FP_SIGN_BIT-1:0]} : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fadd_share_arb_81_if.sv
`default_nettype none
// ============================================================================
// Module      : fadd_share_arb_81_if
// Description : Bus bundle of the float-adder share block.
//   req_valid/req_ready/req_a/req_b/req_sub : requester handshake + operands
//   add_a/add_b/add_result                  : shared adder operands/result
//   rsp_valid/rsp_data                      : one-hot response pulse + data
//   inflight/done_cnt                       : occupancy and completion count
//   enable                                  : grant enable
//   Modport slave = the share block, master = requesters/integration side.
// Revision    : 1.0 - initial release
// ============================================================================
interface fadd_share_arb_81_if #(
  parameter int NREQ = 4,
  parameter int CNTW = 16
);
  import fadd_pkg_81::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [FP_W*NREQ-1:0] req_a;
  logic [FP_W*NREQ-1:0] req_b;
  logic [NREQ-1:0]      req_sub;
  logic [FP_W-1:0]      add_a;
  logic [FP_W-1:0]      add_b;
  logic [FP_W-1:0]      add_result;
  logic [NREQ-1:0]      rsp_valid;
  logic [FP_W-1:0]      rsp_data;
  logic [CNTW-1:0]      inflight;
  logic [CNTW-1:0]      done_cnt;
  logic                 enable;

  modport slave (
    input  req_valid, req_a, req_b, req_sub, add_result, enable,
    output req_ready, add_a, add_b, rsp_valid, rsp_data, inflight, done_cnt
  );

  modport master (
    output req_valid, req_a, req_b, req_sub, add_result, enable,
    input  req_ready, add_a, add_b, rsp_valid, rsp_data, inflight, done_cnt
  );

endinterface
`default_nettype wire

// File: rtl/fadd_share_arb_81_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_81
// Description : Round-robin arbiter with a registered priority pointer.
//   clk81, reset_81 : clock, asynchronous active-high reset
//   req             : request vector
//   enable          : 0 forces an all-zero grant
//   advance         : a grant was taken this cycle; pointer moves past it
//   grant           : one-hot grant (combinational)
//   grant_idx       : encoded index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_81 #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic            clk81,
  input  logic            reset_81,
  input  logic [NREQ-1:0] req,
  input  logic            enable,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] r_ptr;
  logic           w_found;

  // Walk ptr, ptr+1, ... (mod NREQ); the first active request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (enable && !w_found && req[k] &&
            (k == ((int'(r_ptr) + i) % NREQ))) begin
          w_found   = 1'b1;
          grant[k]  = 1'b1;
          grant_idx = IDW'(k);
        end
      end
    end
  end

  always_ff @(posedge clk81 or posedge reset_81) begin
    if (reset_81) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fadd_share_arb_81.sv
`default_nettype none
// ============================================================================
// Module      : fadd_share_arb_81
// Description : Shares one pipelined float adder among NREQ requesters.
//               Round-robin grant, one issue per cycle into registered
//               operands, a tag shift register tracking each operation
//               through the adder, and a one-hot response pulse back to
//               the originator when its result emerges.
//   clk81    : clock
//   reset_81 : asynchronous active-high reset; in-flight work is dropped
//   bus      : fadd_share_arb_81_if.slave (handshake, adder, responses,
//              counters, enable)
// Revision    : 1.0 - initial release
// ============================================================================
module fadd_share_arb_81
  import fadd_pkg_81::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 3,
  parameter int ADD_LAT = ADD_LAT_DEFAULT,
  parameter int CNTW    = 16
) (
  input  logic                 clk81,
  input  logic                 reset_81,
  fadd_share_arb_81_if.slave   bus
);

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_idx;
  logic            w_en_eff;
  logic            w_issue;
  logic [FP_W-1:0] w_sel_a;
  logic [FP_W-1:0] w_sel_b;
  logic            w_sel_sub;
  logic [NREQ-1:0] w_rsp_valid;
  logic [FP_W-1:0] w_rsp_data;
  logic            w_rsp_any;

  logic [FP_W-1:0] r_add_a;
  logic [FP_W-1:0] r_add_b;
  tag_t            r_tag [ADD_LAT+1];
  logic [CNTW-1:0] r_inflight;
  logic [CNTW-1:0] r_done_cnt;

  // Ready must read zero while reset is held, even though the arbiter is
  // combinational off its (already cleared) pointer.
  assign w_en_eff = bus.enable & ~reset_81;
  assign w_issue  = |(bus.req_valid & w_grant);

  rr_arbiter_81 #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk81     (clk81),
    .reset_81  (reset_81),
    .req       (bus.req_valid),
    .enable    (w_en_eff),
    .advance   (w_issue),
    .grant     (w_grant),
    .grant_idx (w_idx)
  );

  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_sub = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_idx == IDW'(k)) begin
        w_sel_a   = bus.req_a[k*FP_W +: FP_W];
        w_sel_b   = bus.req_b[k*FP_W +: FP_W];
        w_sel_sub = bus.req_sub[k];
      end
    end
  end

  // Stage 0 of the tag pipe sits alongside the operand registers; the last
  // stage lines up with the cycle add_result carries that operation.
  always_ff @(posedge clk81 or posedge reset_81) begin
    if (reset_81) begin
      r_add_a    <= '0;
      r_add_b    <= '0;
      r_inflight <= '0;
      r_done_cnt <= '0;
      for (int s = 0; s <= ADD_LAT; s++) begin
        r_tag[s] <= '0;
      end
    end else begin
      if (w_issue) begin
        r_add_a <= w_sel_a;
        r_add_b <= negate_if(w_sel_b, w_sel_sub);
      end
      r_tag[0].valid <= w_issue;
      r_tag[0].id    <= TAG_ID_W'(w_idx);
      for (int s = 1; s <= ADD_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      r_done_cnt <= r_done_cnt + CNTW'(w_rsp_any);
      case ({w_issue, w_rsp_any})
        2'b10:   r_inflight <= r_inflight + CNTW'(1);
        2'b01:   r_inflight <= r_inflight - CNTW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign w_rsp_any = r_tag[ADD_LAT].valid;

  always_comb begin
    w_rsp_valid = '0;
    w_rsp_data  = '0;
    if (r_tag[ADD_LAT].valid) begin
      w_rsp_data = bus.add_result;
      for (int k = 0; k < NREQ; k++) begin
        if (r_tag[ADD_LAT].id == TAG_ID_W'(k)) begin
          w_rsp_valid[k] = 1'b1;
        end
      end
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.add_a     = r_add_a;
  assign bus.add_b     = r_add_b;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = w_rsp_data;
  assign bus.inflight  = r_inflight;
  assign bus.done_cnt  = r_done_cnt;

  a_inflight_max: assert property (@(posedge clk81) disable iff (reset_81)
    r_inflight <= CNTW'(ADD_LAT + 1));

  a_inflight_underflow: assert property (@(posedge clk81) disable iff (reset_81)
    !(w_rsp_any && !w_issue && (r_inflight == '0)));

endmodule
`default_nettype wire
